// File: rtl/load_store_ramp_mc_if.sv
// Bus bundle for load_store_ramp_mc.
//   master: drives en, mode, step, limit_we, limit_in; observes vol, dir, sig, empty
//   slave : the ramp block itself
// Parameters NCH/CBITS/SW must match those given to the ramp block.
interface load_store_ramp_mc_if #(
  parameter int NCH   = 4,
  parameter int CBITS = 19,
  parameter int SW    = 8
);
  logic [NCH-1:0]       en;
  logic                 mode;
  logic [SW-1:0]        step;
  logic                 limit_we;
  logic [CBITS-1:0]     limit_in;
  logic [NCH*CBITS-1:0] vol;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       sig;
  logic [NCH-1:0]       empty;

  modport master (
    output en, mode, step, limit_we, limit_in,
    input  vol, dir, sig, empty
  );

  modport slave (
    input  en, mode, step, limit_we, limit_in,
    output vol, dir, sig, empty
  );
endinterface

// File: rtl/load_store_ramp_mc.sv
// Multi-channel load/store ramp counter. Each channel ramps a level counter
// between 0 and a shared programmable limit, either bouncing (triangle) or
// wrapping to 0 (sawtooth), and flags top (sig) and bottom (empty).
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous reset, active-low
//   bus  - load_store_ramp_mc_if.slave: en/mode/step/limit_we/limit_in in,
//          vol/dir/sig/empty out (all outputs registered)
//
// Per-channel direction FSM:
//   state | meaning
//   DOWN  | descending (triangle) or pending turnaround (sawtooth)
//   UP    | ascending toward lim
module load_store_ramp_mc #(
  parameter int NCH   = 4,
  parameter int CBITS = 19,
  parameter int LIMIT = 400000,
  parameter int SW    = 8
) (
  input logic                 clk,
  input logic                 rst,
  load_store_ramp_mc_if.slave bus
);
  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_e;

  // One spare bit so sums and compares never wrap.
  localparam int W = CBITS + 1;
  localparam logic [CBITS-1:0] LIM_RST = CBITS'(LIMIT);

  logic [CBITS-1:0]     lim_q;
  logic [W-1:0]         lim_w;
  logic [SW-1:0]        step_w;
  logic [W-1:0]         stp;
  logic [NCH*CBITS-1:0] vol_all;
  logic [NCH-1:0]       dir_all, sig_all, empty_all;

  assign step_w = bus.step;
  assign stp    = (step_w == '0) ? W'(1) : W'(step_w);
  assign lim_w  = {1'b0, lim_q};

  // A zero write is dropped so the ramp always has a nonzero span.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lim_q <= LIM_RST;
    end else if (bus.limit_we && (bus.limit_in != '0)) begin
      lim_q <= bus.limit_in;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    dir_e             dir_q, dir_n;
    logic [CBITS-1:0] vol_q;
    logic             sig_q, empty_q;
    logic [W-1:0]     cur, sum, nxt;
    logic             sig_n, empty_n;

    assign cur = {1'b0, vol_q};
    assign sum = cur + stp;

    always_comb begin
      dir_n = dir_q;
      nxt   = cur;
      if (bus.mode == 1'b0) begin
        if (dir_q == UP) begin
          if (cur >= lim_w) dir_n = DOWN;
          else              nxt   = (sum > lim_w) ? lim_w : sum;
        end else begin
          if (cur == '0) dir_n = UP;
          else           nxt   = (cur > stp) ? (cur - stp) : '0;
        end
      end else begin
        // A channel caught descending spends one cycle turning around.
        if (dir_q == DOWN)     dir_n = UP;
        else if (cur >= lim_w) nxt   = '0;
        else                   nxt   = (sum > lim_w) ? lim_w : sum;
      end
      // Pulls the level down after the limit has been lowered below it.
      if (nxt > lim_w) nxt = lim_w;
      sig_n   = (nxt == lim_w);
      empty_n = (nxt == '0);
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        vol_q   <= '0;
        dir_q   <= DOWN;
        sig_q   <= 1'b0;
        empty_q <= 1'b1;
      end else if (bus.en[i]) begin
        vol_q   <= nxt[CBITS-1:0];
        dir_q   <= dir_n;
        sig_q   <= sig_n;
        empty_q <= empty_n;
      end
    end

    assign vol_all[i*CBITS +: CBITS] = vol_q;
    assign dir_all[i]                = dir_q;
    assign sig_all[i]                = sig_q;
    assign empty_all[i]              = empty_q;
  end

  assign bus.vol   = vol_all;
  assign bus.dir   = dir_all;
  assign bus.sig   = sig_all;
  assign bus.empty = empty_all;
endmodule
